// File: rtl/sum_block_avg_if.sv
// Handshake bundle between the sample producer/consumer and sum_block_avg.
// The master side drives samples, clear and out_ready. The slave side (the
// averager) returns the average, its valid flag, the overrun flag and the
// current fill level.
interface sum_block_avg_if #(
  parameter int dim   = 14,
  parameter int LOG2N = 3
);
  logic                 in_valid;
  logic [dim-1:0]       in_data;
  logic                 clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [dim-1:0]       out_data;
  logic                 overrun;
  logic [LOG2N-1:0]     fill;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  out_valid, out_data, overrun, fill
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output out_valid, out_data, overrun, fill
  );
endinterface

// File: rtl/sum_block_avg.sv
// Block averager for the signed adder stream.
// Sums non-overlapping blocks of 2^LOG2N valid samples. Each finished block
// spends one cycle in FLUSH, which loads the floor average into a ready/valid
// output register. A result that finds the output slot still occupied is
// dropped, and the sticky overrun flag is raised. Input is never stalled:
// a sample arriving during FLUSH becomes sample 0 of the next block.
module sum_block_avg #(
  parameter int dim   = 14,
  parameter int LOG2N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  sum_block_avg_if.slave  bus
);

  // The accumulator is wide enough for N full-scale samples, so it cannot overflow.
  localparam int ACC_W = dim + LOG2N;

  // The last sample of a block arrives when fill is all ones (N-1).
  localparam logic [LOG2N-1:0] FILL_LAST = '1;
  localparam logic [LOG2N-1:0] FILL_ONE  = LOG2N'(1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2N-1:0]         fill_q, fill_d;
  logic signed [ACC_W-1:0]  hold_q, hold_d;       // finished block sum (sum_final)
  logic                     out_valid_q, out_valid_d;
  logic [dim-1:0]           out_data_q, out_data_d;
  logic                     overrun_q, overrun_d;

  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic [dim-1:0]           avg;
  logic                     slot_free;

  // Sign-extend the sample before adding it to the wide accumulator.
  assign sample_ext = ACC_W'($signed(bus.in_data));
  assign sum_next   = acc_q + sample_ext;

  // The arithmetic shift rounds toward -infinity. The mean of N dim-bit samples
  // always fits back into dim bits, so the cast drops only sign copies.
  assign avg = dim'(hold_q >>> LOG2N);

  // The output register can take a new value if it is empty, or if its current
  // value is being consumed on this same edge (no bubble).
  assign slot_free = !out_valid_q || bus.out_ready;

  // Next-state logic: FSM, accumulation, output handshake and overrun.
  always_comb begin
    // NOTE: every signal gets a default before any branch. This keeps the block purely combinational and stops latch inference.
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;

    // The consumer takes the held average. A load in FLUSH below overrides this.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // FLUSH lasts exactly one cycle. It either loads the average or drops it.
    if (state_q == ST_FLUSH) begin
      state_d = ST_ACCUM;
      if (slot_free) begin
        out_data_d  = avg;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Accumulation runs in both states, so FLUSH never stalls the input.
    // clear beats a coincident sample, including the Nth one. That block is
    // then lost silently, with no FLUSH and no overrun.
    if (bus.clear) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (bus.in_valid) begin
      if (fill_q == FILL_LAST) begin
        hold_d  = sum_next;
        acc_d   = '0;
        fill_d  = '0;
        state_d = ST_FLUSH;
      end else begin
        acc_d  = sum_next;
        fill_d = fill_q + FILL_ONE;
      end
    end
  end

  // State registers. Synchronous active-low reset drops all partial and pending work.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples the pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      fill_q      <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overrun   = overrun_q;
  assign bus.fill      = fill_q;

endmodule

// File: tb/tb_sum_block_avg.sv
// Self-checking bench for sum_block_avg (dim=14, N=8).
// The reference model collects each block's samples in a queue. It computes the
// mean with integer floor division and tracks one output slot plus a pending
// result that becomes visible one edge after the block completes.
module tb_sum_block_avg;

  localparam int DIM = 14;
  localparam int L2N = 3;
  localparam int N   = 1 << L2N;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sum_block_avg_if #(.dim(DIM), .LOG2N(L2N)) bus ();

  sum_block_avg #(.dim(DIM), .LOG2N(L2N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int  blk[$];
  bit  exp_valid;
  int  exp_data;
  bit  exp_overrun;
  bit  pend;
  int  pend_avg;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sdata();
    return int'($signed(bus.out_data));
  endfunction

  function automatic int floor_mean(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic model_reset();
    blk.delete();
    exp_valid   = 1'b0;
    exp_data    = 0;
    exp_overrun = 1'b0;
    pend        = 1'b0;
    pend_avg    = 0;
  endtask

  // One clock edge of the behavioural model, applied with the inputs presented on that edge.
  task automatic model_edge(input bit iv, input int d, input bit clr, input bit rdy);
    int s;
    if (pend) begin
      if (!exp_valid || rdy) begin
        exp_valid = 1'b1;
        exp_data  = pend_avg;
      end else begin
        exp_overrun = 1'b1;
      end
      pend = 1'b0;
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    if (clr) begin
      blk.delete();
    end else if (iv) begin
      blk.push_back(d);
      if (blk.size() == N) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        pend_avg = floor_mean(s);
        pend     = 1'b1;
        blk.delete();
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", int'(bus.out_valid), int'(exp_valid));
    check("out_data",  sdata(), exp_data);
    check("overrun",   int'(bus.overrun), int'(exp_overrun));
    check("fill",      int'(bus.fill), blk.size());
  endtask

  task automatic step(input bit iv, input int d, input bit clr, input bit rdy);
    bus.in_valid  = iv;
    bus.in_data   = DIM'(d);
    bus.clear     = clr;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(iv, d, clr, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = DIM'(123);
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    compare_all();
    check("rst_valid",   int'(bus.out_valid), 0);
    check("rst_data",    sdata(), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("rst_fill",    int'(bus.fill), 0);
  endtask

  task automatic run_const(input int v, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, v, 1'b0, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 0, 1'b0, rdy);
  endtask

  initial begin
    int pulses;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Samples 1..8: result appears one edge after sample 8, pulses one cycle
    for (int i = 1; i <= N; i++) step(1'b1, i, 1'b0, 1'b1);
    check("latency_not_yet", int'(bus.out_valid), 0);
    idle(1'b1);
    check("pulse_on", int'(bus.out_valid), 1);
    check("avg_1to8", sdata(), 4);
    idle(1'b1);
    check("pulse_off", int'(bus.out_valid), 0);

    // Floor behaviour and extremes
    step(1'b1, -1, 1'b0, 1'b1);
    run_const(0, N - 1, 1'b1);
    idle(1'b1);
    check("avg_floor_m1", sdata(), -1);
    run_const(-3, N, 1'b1);
    idle(1'b1);
    check("avg_m3", sdata(), -3);
    run_const(8191, N, 1'b1);
    idle(1'b1);
    check("avg_max", sdata(), 8191);
    run_const(-8192, N, 1'b1);
    idle(1'b1);
    check("avg_min", sdata(), -8192);
    for (int i = 0; i < N; i++) step(1'b1, (i % 2 == 0) ? 8191 : -8192, 1'b0, 1'b1);
    idle(1'b1);
    check("avg_alt", sdata(), -1);
    idle(1'b1);

    // Overrun: consumer stalled across two blocks
    run_const(5, N + 1, 1'b0);
    check("ovr_first_held", sdata(), 5);
    run_const(5, N - 1, 1'b0);
    idle(1'b0);
    check("ovr_set", int'(bus.overrun), 1);
    check("ovr_data_stable", sdata(), 5);
    check("ovr_valid_held", int'(bus.out_valid), 1);
    idle(1'b1);
    check("ovr_valid_fall", int'(bus.out_valid), 0);
    check("ovr_sticky", int'(bus.overrun), 1);

    // Continuous full-rate input: no gaps, no overrun
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4 * N; i++) begin
      step(1'b1, int'($urandom_range(0, 16383)) - 8192, 1'b0, 1'b1);
      if (bus.out_valid) pulses++;
    end
    idle(1'b1);
    if (bus.out_valid) pulses++;
    check("cont_pulses", pulses, 4);
    check("cont_no_ovr", int'(bus.overrun), 0);
    idle(1'b1);

    // clear handling
    run_const(100, 5, 1'b1);
    step(1'b1, 100, 1'b1, 1'b1);
    check("clear_fill", int'(bus.fill), 0);
    run_const(2, N, 1'b1);
    idle(1'b1);
    check("clear_then_avg", sdata(), 2);
    idle(1'b1);
    run_const(9, N - 1, 1'b1);
    step(1'b1, 9, 1'b1, 1'b1);
    idle(1'b1);
    check("clear_nth_no_out", int'(bus.out_valid), 0);
    check("clear_nth_no_ovr", int'(bus.overrun), 0);

    // Reset mid-block with a result pending
    run_const(1, N, 1'b0);
    idle(1'b0);
    check("pre_rst_pending", int'(bus.out_valid), 1);
    run_const(3, 6, 1'b0);
    do_reset();
    run_const(7, N, 1'b1);
    idle(1'b1);
    check("post_rst_avg", sdata(), 7);
    idle(1'b1);

    // Random gapped traffic with random back-pressure and rare clears
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 16383)) - 8192,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
